// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory port arbiter.
package mem_arb_pkg;

    localparam int NMASTERS = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_DATA = 1'b1
    } state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one word-addressed memory port between the core (master 0) and a secondary master.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise master 0 has fixed priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NBITS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NMASTERS-1:0] mReq,
    input  logic [NMASTERS-1:0] mWe,
    input  logic [NBITS-1:2]    mAddr0,
    input  logic [NBITS-1:2]    mAddr1,
    input  logic [NBITS-1:0]    mWData0,
    input  logic [NBITS-1:0]    mWData1,
    output logic [NBITS-1:0]    mRData,
    output logic [NMASTERS-1:0] mBusy,
    output logic [NBITS-1:2]    memAddress,
    output logic [NBITS-1:0]    memWriteData,
    input  logic [NBITS-1:0]    memReadData,
    output logic                memMemWrite
);

    state_t state;
    state_t next_state;
    logic   owner;
    logic   last;
    logic   grant_valid;
    logic   grant_idx;
    logic   tie_winner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign tie_winner = ~last;
`else
    // Fixed priority: last is kept for observability but masked out of the choice.
    assign tie_winner = last & 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= next_state;
            if (grant_valid) begin
                last <= grant_idx;
                if (!mWe[grant_idx]) begin
                    owner <= grant_idx;
                end
            end
        end
    end

    // Losers always see mBusy = mReq; only the completing master is released.
    always_comb begin
        next_state   = state;
        grant_valid  = 1'b0;
        grant_idx    = 1'b0;
        memAddress   = '0;
        memWriteData = '0;
        memMemWrite  = 1'b0;
        mRData       = '0;
        mBusy        = '0;
        if (reset) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (|mReq) begin
                        grant_valid  = 1'b1;
                        grant_idx    = (mReq == 2'b11) ? tie_winner : ~mReq[0];
                        memAddress   = grant_idx ? mAddr1 : mAddr0;
                        memWriteData = grant_idx ? mWData1 : mWData0;
                        mBusy        = mReq;
                        if (mWe[grant_idx]) begin
                            memMemWrite      = 1'b1;
                            mBusy[grant_idx] = 1'b0;
                        end else begin
                            next_state = RD_DATA;
                        end
                    end
                end
                RD_DATA: begin
                    memAddress   = owner ? mAddr1 : mAddr0;
                    mRData       = memReadData;
                    mBusy        = mReq;
                    mBusy[owner] = 1'b0;
                    next_state   = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a simple synchronous memory model.
module tb_mem_port_arbiter;

    localparam int NBITS = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic [1:0]       mReq;
    logic [1:0]       mWe;
    logic [NBITS-1:2] mAddr0;
    logic [NBITS-1:2] mAddr1;
    logic [NBITS-1:0] mWData0;
    logic [NBITS-1:0] mWData1;
    logic [NBITS-1:0] mRData;
    logic [1:0]       mBusy;
    logic [NBITS-1:2] memAddress;
    logic [NBITS-1:0] memWriteData;
    logic [NBITS-1:0] memReadData;
    logic             memMemWrite;

    logic             load_en;
    logic [NBITS-1:2] load_addr;
    logic [NBITS-1:0] load_data;
    logic [NBITS-1:0] mem [0:63];

    int errors = 0;
    int checks = 0;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    mem_port_arbiter #(.NBITS(NBITS)) dut (
        .clock        (clock),
        .reset        (reset),
        .mReq         (mReq),
        .mWe          (mWe),
        .mAddr0       (mAddr0),
        .mAddr1       (mAddr1),
        .mWData0      (mWData0),
        .mWData1      (mWData1),
        .mRData       (mRData),
        .mBusy        (mBusy),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .memReadData  (memReadData),
        .memMemWrite  (memMemWrite)
    );

    always #5 clock = ~clock;

    // Memory: writes on the edge, read data appears the cycle after the address.
    always @(posedge clock) begin
        if (load_en) mem[load_addr] <= load_data;
        else if (memMemWrite) mem[memAddress] <= memWriteData;
        memReadData <= mem[memAddress];
    end

    task automatic preload(input logic [NBITS-1:2] a, input logic [NBITS-1:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clock);
        load_en = 1'b0;
    endtask

    task automatic do_reset();
        mReq = 2'b00; mWe = 2'b00;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mReq = 2'b11; mWe = 2'b00; mAddr0 = 6'd5; mAddr1 = 6'd6;
        #1;
        checks++; if (mBusy !== 2'b00) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=00", mBusy); end
        checks++; if (memMemWrite !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got=%b exp=0", memMemWrite); end
        checks++; if (memAddress !== 6'd0) begin errors++; $display("[TB] FAIL reset_addr got=%0h exp=0", memAddress); end
        @(negedge clock);
        mReq = 2'b00;
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_single_read();
        mReq = 2'b01; mWe = 2'b00; mAddr0 = 6'h05;
        #1;
        checks++; if (mBusy !== 2'b01) begin errors++; $display("[TB] FAIL rd_c0_busy got=%b exp=01", mBusy); end
        checks++; if (memAddress !== 6'h05) begin errors++; $display("[TB] FAIL rd_c0_addr got=%0h exp=5", memAddress); end
        checks++; if (memMemWrite !== 1'b0) begin errors++; $display("[TB] FAIL rd_c0_we got=%b exp=0", memMemWrite); end
        @(negedge clock); #1;
        checks++; if (mBusy !== 2'b00) begin errors++; $display("[TB] FAIL rd_c1_busy got=%b exp=00", mBusy); end
        checks++; if (mRData !== 8'hA5) begin errors++; $display("[TB] FAIL rd_c1_data got=%0h exp=a5", mRData); end
        checks++; if (memAddress !== 6'h05) begin errors++; $display("[TB] FAIL rd_c1_addr got=%0h exp=5", memAddress); end
        @(negedge clock);
        mReq = 2'b00;
        #1;
        checks++; if (memAddress !== 6'd0) begin errors++; $display("[TB] FAIL rd_idle_addr got=%0h exp=0", memAddress); end
        @(negedge clock);
    endtask

    task automatic test_single_write();
        mReq = 2'b10; mWe = 2'b10; mAddr1 = 6'h03; mWData1 = 8'h3C;
        #1;
        checks++; if (memMemWrite !== 1'b1) begin errors++; $display("[TB] FAIL wr_we got=%b exp=1", memMemWrite); end
        checks++; if (memAddress !== 6'h03) begin errors++; $display("[TB] FAIL wr_addr got=%0h exp=3", memAddress); end
        checks++; if (memWriteData !== 8'h3C) begin errors++; $display("[TB] FAIL wr_data got=%0h exp=3c", memWriteData); end
        checks++; if (mBusy !== 2'b00) begin errors++; $display("[TB] FAIL wr_busy got=%b exp=00", mBusy); end
        @(negedge clock);
        mReq = 2'b00; mWe = 2'b00;
        @(negedge clock);
    endtask

    task automatic test_tie_reads();
        logic             own;
        logic [1:0]       exp_busy;
        logic [NBITS-1:2] exp_addr;
        do_reset();
        mReq = 2'b11; mWe = 2'b00; mAddr0 = 6'd10; mAddr1 = 6'd20;
        for (int k = 0; k < 6; k++) begin
            own = RR ? 1'((k / 2) % 2) : 1'b0;
            exp_addr = own ? 6'd20 : 6'd10;
            #1;
            if (k % 2 == 0) exp_busy = 2'b11;
            else exp_busy = own ? 2'b01 : 2'b10;
            checks++; if (mBusy !== exp_busy) begin errors++; $display("[TB] FAIL tie_busy k=%0d got=%b exp=%b", k, mBusy, exp_busy); end
            checks++; if (memAddress !== exp_addr) begin errors++; $display("[TB] FAIL tie_addr k=%0d got=%0d exp=%0d", k, memAddress, exp_addr); end
            if (k % 2 == 1) begin
                checks++;
                if (mRData !== (own ? 8'h22 : 8'h11)) begin
                    errors++; $display("[TB] FAIL tie_data k=%0d got=%0h exp=%0h", k, mRData, own ? 8'h22 : 8'h11);
                end
            end
            @(negedge clock);
        end
        mReq = 2'b00;
        @(negedge clock);
    endtask

    task automatic test_write_read_tie();
        do_reset();
        mReq = 2'b11; mWe = 2'b01; mAddr0 = 6'd7; mWData0 = 8'h5A; mAddr1 = 6'd2;
        #1;
        checks++; if (memMemWrite !== 1'b1) begin errors++; $display("[TB] FAIL wrt_c0_we got=%b exp=1", memMemWrite); end
        checks++; if (memAddress !== 6'd7) begin errors++; $display("[TB] FAIL wrt_c0_addr got=%0d exp=7", memAddress); end
        checks++; if (mBusy !== 2'b10) begin errors++; $display("[TB] FAIL wrt_c0_busy got=%b exp=10", mBusy); end
        @(negedge clock);
        mReq = 2'b10;
        #1;
        checks++; if (mBusy !== 2'b10) begin errors++; $display("[TB] FAIL wrt_c1_busy got=%b exp=10", mBusy); end
        checks++; if (memAddress !== 6'd2) begin errors++; $display("[TB] FAIL wrt_c1_addr got=%0d exp=2", memAddress); end
        checks++; if (memMemWrite !== 1'b0) begin errors++; $display("[TB] FAIL wrt_c1_we got=%b exp=0", memMemWrite); end
        @(negedge clock); #1;
        checks++; if (mBusy !== 2'b00) begin errors++; $display("[TB] FAIL wrt_c2_busy got=%b exp=00", mBusy); end
        checks++; if (mRData !== 8'h77) begin errors++; $display("[TB] FAIL wrt_c2_data got=%0h exp=77", mRData); end
        @(negedge clock);
        mReq = 2'b00; mWe = 2'b00;
        @(negedge clock);
    endtask

    task automatic test_reset_in_rd_data();
        mReq = 2'b01; mWe = 2'b00; mAddr0 = 6'd4;
        #1;
        checks++; if (mBusy !== 2'b01) begin errors++; $display("[TB] FAIL rst_c0_busy got=%b exp=01", mBusy); end
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++; if (mBusy !== 2'b00) begin errors++; $display("[TB] FAIL rst_c1_busy got=%b exp=00", mBusy); end
        checks++; if (memMemWrite !== 1'b0) begin errors++; $display("[TB] FAIL rst_c1_we got=%b exp=0", memMemWrite); end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (mBusy !== 2'b01) begin errors++; $display("[TB] FAIL rst_c2_busy got=%b exp=01", mBusy); end
        checks++; if (memAddress !== 6'd4) begin errors++; $display("[TB] FAIL rst_c2_addr got=%0d exp=4", memAddress); end
        checks++; if (memMemWrite !== 1'b0) begin errors++; $display("[TB] FAIL rst_c2_we got=%b exp=0", memMemWrite); end
        @(negedge clock); #1;
        checks++; if (mBusy !== 2'b00) begin errors++; $display("[TB] FAIL rst_c3_busy got=%b exp=00", mBusy); end
        checks++; if (mRData !== 8'h44) begin errors++; $display("[TB] FAIL rst_c3_data got=%0h exp=44", mRData); end
        @(negedge clock);
        mReq = 2'b00;
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        mReq = 2'b01; mWe = 2'b01;
        for (int i = 0; i < 3; i++) begin
            mAddr0 = 6'(30 + i); mWData0 = 8'(8'hC0 + i);
            #1;
            checks++; if (mBusy !== 2'b00) begin errors++; $display("[TB] FAIL b2b_busy i=%0d got=%b exp=00", i, mBusy); end
            checks++; if (memMemWrite !== 1'b1) begin errors++; $display("[TB] FAIL b2b_we i=%0d got=%b exp=1", i, memMemWrite); end
            checks++; if (memAddress !== 6'(30 + i)) begin errors++; $display("[TB] FAIL b2b_addr i=%0d got=%0d exp=%0d", i, memAddress, 30 + i); end
            @(negedge clock);
        end
        mWe = 2'b00; mAddr0 = 6'd31;
        #1;
        checks++; if (mBusy !== 2'b01) begin errors++; $display("[TB] FAIL b2b_rd_busy got=%b exp=01", mBusy); end
        @(negedge clock); #1;
        checks++; if (mRData !== 8'hC1) begin errors++; $display("[TB] FAIL b2b_rd_data got=%0h exp=c1", mRData); end
        @(negedge clock);
        mReq = 2'b00;
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        mReq = 2'b00; mWe = 2'b00;
        mAddr0 = '0; mAddr1 = '0; mWData0 = '0; mWData1 = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        @(negedge clock);
        preload(6'd5,  8'hA5);
        preload(6'd10, 8'h11);
        preload(6'd20, 8'h22);
        preload(6'd2,  8'h77);
        preload(6'd4,  8'h44);

        test_reset();
        test_single_read();
        test_single_write();
        test_tie_reads();
        test_write_read_tie();
        test_reset_in_rd_data();
        test_back_to_back();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
